// File: rtl/row_scan_decoder.sv
// Registered one-hot row decoder with a direct mode and an auto-stepping scan mode.
// Every output comes straight from a flop; inputs reach the outputs only through a clock edge.
module row_scan_decoder #(
   parameter int unsigned ADDR_W  = 3,
   parameter bit          REVERSE = 1'b1,
   parameter int unsigned DWELL   = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   mode,
   input  logic [ADDR_W-1:0]      addr_in,
   input  logic                   hold,
   output logic [(2**ADDR_W)-1:0] row,
   output logic [ADDR_W-1:0]      cur_addr,
   output logic                   valid,
   output logic                   wrap
);

   localparam int unsigned      ROWS     = 2**ADDR_W;
   localparam int unsigned      CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DWELL - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   typedef enum logic [1:0] {StOff, StDirect, StScan} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_d;
   logic                wrap_d;
   logic                valid_d;
   logic [ROWS-1:0]     row_d;

   // With REVERSE, address 0 lights the top row; ~a equals ROWS-1-a.
   function automatic logic [ROWS-1:0] decode(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] idx;
      idx       = REVERSE ? ~a : a;
      decode    = '0;
      decode[idx] = 1'b1;
   endfunction

   always_comb begin
      state_d = state_q;
      addr_d  = cur_addr;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      if (!en) begin
         state_d = StOff;
         cnt_d   = '0;
      end else if (!mode) begin
         state_d = StDirect;
         addr_d  = addr_in;
         cnt_d   = '0;
      end else if (state_q != StScan) begin
         state_d = StScan;
         addr_d  = addr_in;
         cnt_d   = '0;
      end else if (!hold) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            addr_d = cur_addr + ADDR_W'(1);
            wrap_d = (cur_addr == ADDR_MAX);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      valid_d = (state_d != StOff);
      row_d   = valid_d ? decode(addr_d) : '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StOff;
         cur_addr <= '0;
         cnt_q    <= '0;
         row      <= '0;
         valid    <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_addr <= addr_d;
         cnt_q    <= cnt_d;
         row      <= row_d;
         valid    <= valid_d;
         wrap     <= wrap_d;
      end
   end

endmodule
